// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell used by the serial adder; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// publishing sum/cout and a one-cycle done pulse after WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic             busy_next;
  logic             done_next;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (bit_cnt == LAST_BIT);

  full_adder u_full_adder (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register, with busy/done registered alongside so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic; DONE can restart directly so back-to-back needs no idle cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (bit_cnt == LAST_BIT) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    busy_next = (next_state == RUN);
    done_next = last_bit;
  end

  // Datapath: operand shifters, carry, bit counter and result; sum/cout only
  // change on the final bit so partial results are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      carry   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      op_a    <= a;
      op_b    <= b;
      carry   <= cin;
      bit_cnt <= '0;
      res     <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fa_cout;
      res   <= {fa_s, res[WIDTH-1:1]};
      if (last_bit) begin
        sum  <= {fa_s, res[WIDTH-1:1]};
        cout <= fa_cout;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
